// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1/8N2 UART transmitter with internal bit-rate divider
// One byte is accepted per TX_EN/TX_STATUS handshake and shifted out LSB first.
module uart_tx #(
  parameter int unsigned CLK_DIV   = 5208,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] TX_DATA,
  input  logic       TX_EN,
  output logic       TX_STATUS,
  output logic       UART_TX
);

  localparam int unsigned    DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic           STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       bit_idx;
  logic             stop_cnt;
  logic [7:0]       shift_reg;

  logic             accept;
  logic             div_wrap;
  logic             last_bit;
  logic             last_stop;
  logic             uart_tx_d;
  logic             tx_status_d;

  assign accept    = TX_EN && TX_STATUS;
  assign div_wrap  = (div_cnt == DIV_LAST);
  assign last_bit  = (bit_idx == 3'd7);
  assign last_stop = (stop_cnt == STOP_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept)                 next_state = START;
      START:   if (div_wrap)               next_state = DATA;
      DATA:    if (div_wrap && last_bit)   next_state = STOP;
      STOP:    if (div_wrap && last_stop)  next_state = IDLE;
      default:                             next_state = IDLE;
    endcase
  end

  // Next line level and status; both are registered so the line only moves on
  // accept, divider wrap or reset edges.
  always_comb begin
    uart_tx_d   = UART_TX;
    tx_status_d = TX_STATUS;
    case (state)
      IDLE: begin
        uart_tx_d   = !accept;
        tx_status_d = !accept;
      end
      START: begin
        if (div_wrap) uart_tx_d = shift_reg[0];
      end
      DATA: begin
        if (div_wrap) uart_tx_d = last_bit ? 1'b1 : shift_reg[1];
      end
      STOP: begin
        uart_tx_d = 1'b1;
        if (div_wrap && last_stop) tx_status_d = 1'b1;
      end
      default: begin
        uart_tx_d   = 1'b1;
        tx_status_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt   <= '0;
      bit_idx   <= 3'd0;
      stop_cnt  <= 1'b0;
      shift_reg <= 8'd0;
      UART_TX   <= 1'b1;
      TX_STATUS <= 1'b1;
    end else begin
      UART_TX   <= uart_tx_d;
      TX_STATUS <= tx_status_d;
      if (accept) begin
        shift_reg <= TX_DATA;
        div_cnt   <= '0;
        bit_idx   <= 3'd0;
        stop_cnt  <= 1'b0;
      end else if (state != IDLE) begin
        div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
        if (div_wrap && state == DATA) begin
          shift_reg <= shift_reg >> 1;
          bit_idx   <= bit_idx + 3'd1;
        end
        // With one stop bit the counter never leaves zero.
        if (div_wrap && state == STOP) begin
          stop_cnt <= last_stop ? 1'b0 : 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx (1 and 2 stop bit instances)
module tb_uart_tx;
  localparam int D = 4;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [2];
  logic       tx_en [2];
  logic [7:0] tx_data [2];
  logic       line0, line1, stat0, stat1;

  uart_tx #(.CLK_DIV(D), .STOP_BITS(1)) dut1 (
    .clk(clk), .reset(rst[0]), .TX_DATA(tx_data[0]), .TX_EN(tx_en[0]),
    .TX_STATUS(stat0), .UART_TX(line0));

  uart_tx #(.CLK_DIV(D), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(rst[1]), .TX_DATA(tx_data[1]), .TX_EN(tx_en[1]),
    .TX_STATUS(stat1), .UART_TX(line1));

  int nerr = 0;
  int nchk = 0;
  int cyc  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic get_line(input int n);
    return (n == 0) ? line0 : line1;
  endfunction

  function automatic logic get_stat(input int n);
    return (n == 0) ? stat0 : stat1;
  endfunction

  // Reference model: a frame is a list of levels, each held D cycles after accept.
  bit          busy [2];
  int          k [2];
  logic [11:0] fr [2];
  logic        eline [2];
  logic        estat [2];
  bit          mvalid [2];

  always @(posedge clk) begin
    int kn;
    cyc <= cyc + 1;
    for (int n = 0; n < 2; n++) begin
      if (rst[n] === 1'b1) begin
        busy[n] <= 1'b0; eline[n] <= 1'b1; estat[n] <= 1'b1; mvalid[n] <= 1'b1;
      end else if (!busy[n]) begin
        if (tx_en[n] === 1'b1) begin
          busy[n] <= 1'b1; k[n] <= 0; fr[n] <= {2'b11, tx_data[n], 1'b0};
          eline[n] <= 1'b0; estat[n] <= 1'b0;
        end else begin
          eline[n] <= 1'b1; estat[n] <= 1'b1;
        end
      end else begin
        kn = k[n] + 1;
        k[n] <= kn;
        if (kn == (10 + n) * D) begin
          busy[n] <= 1'b0; eline[n] <= 1'b1; estat[n] <= 1'b1;
        end else begin
          eline[n] <= fr[n][kn / D]; estat[n] <= 1'b0;
        end
      end
    end
  end

  int   acc_q[$];
  logic pstat0 = 1'b0;
  logic pline0 = 1'b0;
  int   run0 = 0;
  int   last_run0 = 0;

  always @(negedge clk) begin
    for (int n = 0; n < 2; n++) begin
      if (mvalid[n]) begin
        chk(n == 0 ? "s1_line" : "s2_line", {31'd0, get_line(n)}, {31'd0, eline[n]});
        chk(n == 0 ? "s1_status" : "s2_status", {31'd0, get_stat(n)}, {31'd0, estat[n]});
      end
    end
    if (pstat0 === 1'b1 && stat0 === 1'b0) acc_q.push_back(cyc);
    pstat0 = stat0;
    if (line0 === 1'b1) run0++;
    else begin
      if (pline0 === 1'b1) last_run0 = run0;
      run0 = 0;
    end
    pline0 = line0;
  end

  logic smp [64];
  logic msmp [64];
  int   lowc;

  task automatic send_capture(input int n, input logic [7:0] d, input bit poke);
    bit done;
    done = 1'b0;
    lowc = 0;
    tx_data[n] = d; tx_en[n] = 1'b1;
    @(posedge clk); #2 tx_en[n] = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (get_stat(n) === 1'b1) begin done = 1'b1; break; end
      smp[i] = get_line(n);
      msmp[i] = eline[n];
      lowc++;
      if (poke && i == 10) begin tx_en[n] = 1'b1; tx_data[n] = 8'hFF; end
      if (poke && i == 14) tx_en[n] = 1'b0;
    end
    if (!done) begin
      nchk++; nerr++;
      $display("FAIL capture_timeout: frame on instance %0d never ended", n);
    end
  endtask

  task automatic rand_drive(input int n);
    for (int j = 0; j < 10; j++) begin
      repeat ($urandom_range(0, 30)) @(posedge clk);
      #2;
      if ($urandom_range(0, 9) == 0) begin
        rst[n] = 1'b1;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #2 rst[n] = 1'b0;
      end else begin
        tx_data[n] = 8'($urandom);
        tx_en[n] = 1'b1;
        repeat ($urandom_range(1, 60)) begin
          @(posedge clk); #2 tx_data[n] = 8'($urandom);
        end
        tx_en[n] = 1'b0;
      end
    end
    repeat (60) @(posedge clk);
  endtask

  logic [9:0] lit;
  logic [7:0] dv;
  int         cnt;

  initial begin
    rst[0] = 1'b1; rst[1] = 1'b1;
    tx_en[0] = 1'b0; tx_en[1] = 1'b0;
    tx_data[0] = 8'd0; tx_data[1] = 8'd0;
    repeat (3) @(posedge clk);
    #2 rst[0] = 1'b0; rst[1] = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_line", {31'd0, line0}, 32'd1);
    chk("idle_status", {31'd0, stat0}, 32'd1);

    // A5 with one stop bit: 0,1,0,1,0,0,1,0,1,1
    send_capture(0, 8'hA5, 1'b0);
    lit = 10'b1101001010;
    for (int i = 0; i < 10; i++) begin
      chk("a5_bit", {31'd0, smp[4*i+2]}, {31'd0, lit[i]});
      chk("a5_model_bit", {31'd0, msmp[4*i+2]}, {31'd0, lit[i]});
    end
    chk("a5_low_cycles", lowc, 40);

    // 3C with a mid-frame request that must be ignored
    send_capture(0, 8'h3C, 1'b1);
    dv = 8'h3C;
    for (int i = 0; i < 8; i++) chk("3c_bit", {31'd0, smp[4*(i+1)+2]}, {31'd0, dv[i]});
    chk("3c_low_cycles", lowc, 40);
    cnt = 0;
    repeat (20) begin @(negedge clk); if (stat0 !== 1'b1) cnt++; end
    chk("3c_no_second_frame", cnt, 0);

    // Back-to-back with TX_EN held high
    acc_q.delete();
    tx_data[0] = 8'h00; tx_en[0] = 1'b1;
    cnt = 0;
    while (acc_q.size() < 1 && cnt < 200) begin @(negedge clk); cnt++; end
    tx_data[0] = 8'h55;
    while (acc_q.size() < 2 && cnt < 200) begin @(negedge clk); cnt++; end
    tx_en[0] = 1'b0;
    if (acc_q.size() >= 2) begin
      chk("b2b_gap", acc_q[1] - acc_q[0], 41);
      chk("b2b_idle_run", last_run0, 5);
    end else begin
      nchk++; nerr++;
      $display("FAIL b2b_timeout: saw %0d accepts, need 2", acc_q.size());
    end
    cnt = 0;
    while (stat0 !== 1'b1 && cnt < 100) begin @(negedge clk); cnt++; end
    repeat (3) @(negedge clk);

    // Reset in the middle of data bit 3
    tx_data[0] = 8'h00; tx_en[0] = 1'b1;
    @(posedge clk); #2 tx_en[0] = 1'b0;
    repeat (18) @(negedge clk);
    rst[0] = 1'b1;
    @(posedge clk); #2 rst[0] = 1'b0;
    @(negedge clk);
    chk("rst_mid_line", {31'd0, line0}, 32'd1);
    chk("rst_mid_status", {31'd0, stat0}, 32'd1);
    repeat (2) @(negedge clk);
    send_capture(0, 8'h81, 1'b0);
    lit = 10'b1100000010;
    for (int i = 0; i < 10; i++) chk("81_bit", {31'd0, smp[4*i+2]}, {31'd0, lit[i]});
    chk("81_low_cycles", lowc, 40);

    // Two stop bits
    send_capture(1, 8'h01, 1'b0);
    chk("s2_low_cycles", lowc, 44);
    chk("s2_bit0", {31'd0, smp[6]}, 32'd1);
    chk("s2_bit7", {31'd0, smp[35]}, 32'd0);
    cnt = 0;
    for (int i = 36; i < 44; i++) if (smp[i] === 1'b1) cnt++;
    chk("s2_stop_ones", cnt, 8);

    fork
      rand_drive(0);
      rand_drive(1);
    join

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
